// File: rtl/strobe_capture_fifo_if.sv
// Output handshake bundle of strobe_capture_fifo.
//   out_valid : head entry present (driven by the FIFO)
//   out_ready : consumer accepts the head entry (driven by the consumer)
//   out_data  : head entry, don't-care while out_valid=0
interface strobe_capture_fifo_if #(
    parameter int unsigned W = 1
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/strobe_capture_fifo.sv
// Strobe-qualified capture into a small FIFO.
// A strobe q is qualified from the request lines under a 2-bit mode. Each rising
// edge of q captures data_in into the FIFO and into last_data. The FIFO drains
// through a valid/ready interface. A capture that finds the FIFO full without a
// pop in the same cycle is dropped and sets the sticky overflow flag.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   req, mode  : request lines and qualifier select
//   data_in    : word sampled on a capture
//   clr_ovf    : clears overflow; a drop in the same cycle takes priority
//   out        : valid/ready FIFO head port (master side)
//   last_data  : most recent captured word
//   count      : FIFO occupancy, 0..DEPTH
//   overflow   : sticky drop flag
module strobe_capture_fifo #(
    parameter int unsigned W     = 1,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req,
    input  logic [1:0]                   mode,
    input  logic [W-1:0]                 data_in,
    input  logic                         clr_ovf,
    strobe_capture_fifo_if.master        out,
    output logic [W-1:0]                 last_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_next;
    logic          q;
    logic          q_d;
    logic          capture;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    always_comb begin
        q = 1'b0;
        case (mode)
            2'b11:   q = |req[NREQ-1:NREQ/2];
            2'b10:   q = 1'b0;
            default: q = |req;
        endcase
    end

    assign capture = q & ~q_d;
    assign full    = (count == CW'(DEPTH));
    assign pop     = out.out_valid & out.out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_d           <= 1'b1;  // q already high at release must not capture
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            out.out_valid <= 1'b0;
            overflow      <= 1'b0;
            last_data     <= '0;
        end else begin
            q_d           <= q;
            count         <= count_next;
            out.out_valid <= (count_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (capture) begin
                last_data <= data_in;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; writes are gated so nothing lands during reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign out.out_data = mem[rd_ptr];
endmodule

// File: tb/tb_strobe_capture_fifo.sv
module tb_strobe_capture_fifo;
    localparam int unsigned W     = 8;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [1:0]   mode;
    logic [7:0]   data_in;
    logic         clr_ovf;
    logic [7:0]   last_data;
    logic [2:0]   count;
    logic         overflow;

    int checks = 0;
    int failures = 0;

    strobe_capture_fifo_if #(.W(W)) bus ();

    strobe_capture_fifo #(.W(W), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .data_in   (data_in),
        .clr_ovf   (clr_ovf),
        .out       (bus),
        .last_data (last_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] mode;
        logic [7:0] din;
        logic       rdy;
        logic [2:0] ecount;
        logic       evalid;
        logic [7:0] elast;
        logic       chk_head;
        logic [7:0] ehead;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [3:0] r, logic [1:0] m, logic [7:0] d, logic rd,
                                logic [2:0] ec, logic ev, logic [7:0] el, logic ch,
                                logic [7:0] eh);
        vec_t v;
        v.req = r; v.mode = m; v.din = d; v.rdy = rd;
        v.ecount = ec; v.evalid = ev; v.elast = el; v.chk_head = ch; v.ehead = eh;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next posedge; outputs are then stable for sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] r, logic [1:0] m, logic [7:0] d, logic rd, logic c);
        req = r; mode = m; data_in = d; bus.out_ready = rd; clr_ovf = c;
    endtask

    // One rising edge of q (mode 00) carrying word d, then q back low.
    task automatic edge_push(logic [7:0] d, logic rd);
        drive(4'b0001, 2'b00, d, rd, 1'b0);
        cyc();
        drive(4'b0000, 2'b00, 8'h00, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic drain_expect(string name, logic [7:0] e0, logic [7:0] e1,
                                logic [7:0] e2, logic [7:0] e3);
        logic [7:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int i = 0; i < 4; i++) begin
            chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
            chk({name, "_data"}, 32'(bus.out_data), 32'(exp[i]));
            drive(4'b0000, 2'b00, 8'h00, 1'b1, 1'b0);
            cyc();
        end
        drive(4'b0000, 2'b00, 8'h00, 1'b0, 1'b0);
        chk({name, "_empty"}, 32'(count), 32'd0);
        chk({name, "_nvalid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(4'b1111, 2'b00, 8'h00, 1'b0, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_last", 32'(last_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Mode qualification and edge-only behaviour.
        vt.push_back(mk(4'b0000, 2'b00, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00));
        vt.push_back(mk(4'b0001, 2'b11, 8'h11, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00));
        vt.push_back(mk(4'b0000, 2'b11, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00));
        vt.push_back(mk(4'b1000, 2'b11, 8'hA5, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b1, 8'hA5));
        vt.push_back(mk(4'b0000, 2'b11, 8'h00, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b1, 8'hA5));
        vt.push_back(mk(4'b1111, 2'b10, 8'h33, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b1, 8'hA5));
        vt.push_back(mk(4'b0000, 2'b10, 8'h00, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b1, 8'hA5));
        vt.push_back(mk(4'b0000, 2'b00, 8'h00, 1'b1, 3'd0, 1'b0, 8'hA5, 1'b0, 8'h00));
        vt.push_back(mk(4'b0010, 2'b00, 8'h10, 1'b0, 3'd1, 1'b1, 8'h10, 1'b1, 8'h10));
        for (int i = 1; i < 10; i++) begin
            vt.push_back(mk(4'b0010, 2'b00, 8'(8'h10 + i), 1'b0, 3'd1, 1'b1, 8'h10, 1'b1,
                            8'h10));
        end
        vt.push_back(mk(4'b0000, 2'b00, 8'h00, 1'b1, 3'd0, 1'b0, 8'h10, 1'b0, 8'h00));

        foreach (vt[i]) begin
            drive(vt[i].req, vt[i].mode, vt[i].din, vt[i].rdy, 1'b0);
            cyc();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].ecount));
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].evalid));
            chk($sformatf("vec%0d_last", i), 32'(last_data), 32'(vt[i].elast));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'd0);
            if (vt[i].chk_head) begin
                chk($sformatf("vec%0d_head", i), 32'(bus.out_data), 32'(vt[i].ehead));
            end
        end

        // Fill past capacity: fifth word is dropped.
        for (int i = 1; i <= 5; i++) edge_push(8'(i), 1'b0);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_last", 32'(last_data), 32'd5);
        drain_expect("drain1", 8'd1, 8'd2, 8'd3, 8'd4);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        drive(4'b0000, 2'b00, 8'h00, 1'b0, 1'b1);
        cyc();
        drive(4'b0000, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Full with simultaneous capture and pop.
        for (int i = 1; i <= 4; i++) edge_push(8'(i), 1'b0);
        chk("full_count", 32'(count), 32'd4);
        drive(4'b0001, 2'b00, 8'd9, 1'b1, 1'b0);
        cyc();
        drive(4'b0000, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_last", 32'(last_data), 32'd9);
        cyc();
        drain_expect("drain2", 8'd2, 8'd3, 8'd4, 8'd9);

        // Drop and clear in the same cycle: set wins.
        for (int i = 1; i <= 4; i++) edge_push(8'(i), 1'b0);
        drive(4'b0001, 2'b00, 8'd7, 1'b0, 1'b1);
        cyc();
        drive(4'b0000, 2'b00, 8'h00, 1'b0, 1'b0);
        chk("setwins_ovf", 32'(overflow), 32'd1);
        chk("setwins_count", 32'(count), 32'd4);
        cyc();
        drain_expect("drain3", 8'd1, 8'd2, 8'd3, 8'd4);

        // Push/pop pairs walk the pointers around the ring several times.
        for (int k = 0; k < 10; k++) begin
            drive(4'b0001, 2'b00, 8'(8'h40 + k), 1'b0, 1'b0);
            cyc();
            drive(4'b0000, 2'b00, 8'h00, 1'b1, 1'b0);
            chk($sformatf("wrap%0d_data", k), 32'(bus.out_data), 32'(8'h40 + k));
            cyc();
            drive(4'b0000, 2'b00, 8'h00, 1'b0, 1'b0);
            chk($sformatf("wrap%0d_count", k), 32'(count), 32'd0);
        end

        // Mid-operation reset with q held high across release.
        for (int i = 1; i <= 3; i++) edge_push(8'(i), 1'b0);
        chk("mid_count", 32'(count), 32'd3);
        drive(4'b1111, 2'b00, 8'hEE, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_last", 32'(last_data), 32'd0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("rel_count", 32'(count), 32'd0);
        chk("rel_valid", 32'(bus.out_valid), 32'd0);
        chk("rel_last", 32'(last_data), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
